// File: rtl/regfile_wb_pkg.sv
// Shared register-file definitions for the MEM/WB write-back slice.
package regfile_wb_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

   localparam logic RstEnable   = 1'b1;
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b1;
   localparam logic ChipEnable  = 1'b1;

endpackage

// File: rtl/regfile_wb_rf_read_port.sv
// One ID-stage read port: priority mux over reset, $0, same-cycle bypass and storage.
module rf_read_port
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] store_data,
   output logic [DATA_W-1:0] rdata
);

   always_comb begin
      rdata = '0;
      if (rst == RstEnable)
         rdata = '0;
      else if (raddr == ADDR_W'(NOPRegAddr))
         rdata = '0;
      else if (re == ReadEnable && we == WriteEnable && waddr == raddr)
         rdata = wdata;
      else if (re == ReadEnable)
         rdata = store_data;
      else
         rdata = '0;
   end

endmodule

// File: rtl/regfile_wb.sv
// General-purpose register file fed by the MEM/WB write-back bus, with two
// bypassed ID read ports, an unbypassed debug port and an accepted-write counter.
module regfile_wb
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W   = RegBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int NUM_REGS = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       wr_count
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [31:0]       r_wr_count;
   logic              w_wr_accept;

   // $0 is never written, so its storage stays at the reset value of zero.
   assign w_wr_accept = (we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr));

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
         r_wr_count <= '0;
      end else if (w_wr_accept) begin
         r_regs[waddr] <= wdata;
         r_wr_count    <= r_wr_count + 32'd1;
      end
   end

   assign wr_count = r_wr_count;

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rst        (rst),
      .re         (re1),
      .raddr      (raddr1),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .store_data (r_regs[raddr1]),
      .rdata      (rdata1)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rst        (rst),
      .re         (re2),
      .raddr      (raddr2),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .store_data (r_regs[raddr2]),
      .rdata      (rdata2)
   );

   always_comb begin
      dbg_data = '0;
      if (rst != RstEnable && dbg_addr != ADDR_W'(NOPRegAddr))
         dbg_data = r_regs[dbg_addr];
   end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, write/read, bypass, $0, read enable,
// reset mid-operation and write-counter wrap.
module tb_regfile_wb;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] wr_count;

   int n_chk;
   int n_fail;

   regfile_wb dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .re1      (re1),
      .raddr1   (raddr1),
      .rdata1   (rdata1),
      .re2      (re2),
      .raddr2   (raddr2),
      .rdata2   (rdata2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b1;
      we       = 1'b0;
      waddr    = '0;
      wdata    = '0;
      re1      = 1'b0;
      raddr1   = '0;
      re2      = 1'b0;
      raddr2   = '0;
      dbg_addr = '0;

      // 1. reset
      #2;
      tick();
      rst = 1'b0;
      re1 = 1'b1;
      re2 = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         raddr1   = 5'(i);
         raddr2   = 5'(31 - i);
         #1;
         chk("reset_dbg", dbg_data, 32'h0);
         chk("reset_rd1", rdata1, 32'h0);
         chk("reset_rd2", rdata2, 32'h0);
      end
      chk("reset_wrcnt", wr_count, 32'h0);

      // 2. write then read
      we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
      re1 = 1'b0; re2 = 1'b0;
      tick();
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
      #1;
      chk("wr_rd_rd1", rdata1, 32'h1234_5678);
      chk("wr_rd_wrcnt", wr_count, 32'd1);

      // 3. bypass on both ports; debug sees old storage
      we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
      re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7; dbg_addr = 5'd7;
      #1;
      chk("byp_rd1", rdata1, 32'hDEAD_BEEF);
      chk("byp_rd2", rdata2, 32'hDEAD_BEEF);
      chk("byp_dbg_old", dbg_data, 32'h0);
      re1 = 1'b0;
      #1;
      chk("byp_re_off", rdata1, 32'h0);
      tick();
      we = 1'b0;
      #1;
      chk("byp_dbg_new", dbg_data, 32'hDEAD_BEEF);
      chk("byp_wrcnt", wr_count, 32'd2);

      // 4. $0 write ignored
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; dbg_addr = 5'd0;
      #1;
      chk("r0_rd1_same", rdata1, 32'h0);
      chk("r0_rd2_same", rdata2, 32'h0);
      chk("r0_dbg_same", dbg_data, 32'h0);
      tick();
      we = 1'b0;
      #1;
      chk("r0_rd1_next", rdata1, 32'h0);
      chk("r0_rd2_next", rdata2, 32'h0);
      chk("r0_dbg_next", dbg_data, 32'h0);
      chk("r0_wrcnt", wr_count, 32'd2);

      // 5. read enable gating
      we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
      tick();
      we = 1'b0; re2 = 1'b0; raddr2 = 5'd3;
      #1;
      chk("re2_low", rdata2, 32'h0);
      re2 = 1'b1;
      #1;
      chk("re2_high", rdata2, 32'hA5A5_A5A5);
      raddr1 = 5'd5;
      #1;
      chk("rd1_r5_kept", rdata1, 32'h1234_5678);
      chk("re_wrcnt", wr_count, 32'd3);

      // 6. reset mid-operation, write in the reset cycle is dropped
      rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
      raddr1 = 5'd5; raddr2 = 5'd3; dbg_addr = 5'd7;
      #1;
      chk("rst_rd1", rdata1, 32'h0);
      chk("rst_rd2", rdata2, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
      tick();
      rst = 1'b0; we = 1'b0;
      dbg_addr = 5'd9;
      #1;
      chk("rst_r9", dbg_data, 32'h0);
      dbg_addr = 5'd7;
      #1;
      chk("rst_r7", dbg_data, 32'h0);
      chk("rst_rd1_after", rdata1, 32'h0);
      chk("rst_wrcnt", wr_count, 32'h0);

      // wr_count wrap from a preloaded all-ones value
      force dut.r_wr_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_wr_count;
      #1;
      chk("wrap_preload", wr_count, 32'hFFFF_FFFF);
      we = 1'b1; waddr = 5'd4; wdata = 32'h0000_0011;
      tick();
      we = 1'b0; dbg_addr = 5'd4;
      #1;
      chk("wrap_wrcnt", wr_count, 32'h0);
      chk("wrap_r4", dbg_data, 32'h0000_0011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
